fcl_bus_servo_pwm: RTL and testbench



---
 rtl/fcl_bus_servo_pwm.sv | 178 +++++++++++++++++
 tb/tb_fcl_bus_servo_pwm.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcl_bus_servo_pwm.sv
// fcl_bus_servo_pwm
//   Word-bus slave holding one pulse-width register per RC-servo channel plus
//   an enable bit, and generating the PWM pulses for every channel. Pulse
//   widths and the enable are copied into shadow registers at each frame
//   start, so a bus write can never cut or stretch a pulse already running.
//
// Ports
//   clk_in, reset_in  system clock, synchronous active-high reset
//   bus_addr_in       word address (32-word window at BASE_ADDR)
//   bus_data_in       write data
//   bus_read_in       one-cycle read strobe
//   bus_write_in      one-cycle write strobe (wins over a simultaneous read)
//   bus_ack_out       one-cycle acknowledge, the cycle after the strobe
//   bus_data_out      read data, zero whenever bus_ack_out is low
//   servo_pwm_out     one PWM output per channel
//   frame_out         one-cycle pulse at each frame start
//
// Bus handshake: there is no back-pressure. A strobe in cycle T that hits the
// window is latched with its address and data and acked in T+1 with read data;
// a write lands in the register at the end of T+1. A new strobe may be issued
// in the ack cycle. Out-of-window strobes get no ack and data stays zero so
// several slaves can be OR-ed together.
module fcl_bus_servo_pwm #(
   parameter logic [15:0] BASE_ADDR = 16'h0100,
   parameter int          N_CH      = 18,
   parameter int          CLK_DIV   = 50,
   parameter int          FRAME_US  = 20000,
   parameter int          PW_MIN    = 500,
   parameter int          PW_MAX    = 2500
) (
   input  logic            clk_in,
   input  logic            reset_in,
   input  logic [15:0]     bus_addr_in,
   input  logic [15:0]     bus_data_in,
   output logic [15:0]     bus_data_out,
   input  logic            bus_read_in,
   input  logic            bus_write_in,
   output logic            bus_ack_out,
   output logic [N_CH-1:0] servo_pwm_out,
   output logic            frame_out
);

   localparam int            TW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int            UW        = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
   localparam logic [UW-1:0] US_LAST   = UW'(FRAME_US - 1);
   localparam logic [15:0]   PW_MIN_W  = 16'(PW_MIN);
   localparam logic [15:0]   PW_MAX_W  = 16'(PW_MAX);

   // latched bus request
   logic        req_q, req_d;
   logic        req_wr_q, req_wr_d;
   logic [4:0]  req_off_q, req_off_d;
   logic [15:0] req_data_q, req_data_d;

   // programmable registers
   logic        en_q, en_d;
   logic [15:0] fcnt_q, fcnt_d;
   logic [15:0] pw_q [N_CH];
   logic [15:0] pw_d [N_CH];

   // frame-stable copies driving the outputs
   logic        shadow_en_q, shadow_en_d;
   logic [15:0] shadow_pw_q [N_CH];
   logic [15:0] shadow_pw_d [N_CH];

   logic [TW-1:0]   tick_q, tick_d;
   logic [UW-1:0]   us_q, us_d;
   logic [N_CH-1:0] pwm_q, pwm_d;
   logic            frame_q, frame_d;

   logic            frame_start;
   logic [15:0]     rdata;

   function automatic logic [15:0] clamp_pw(input logic [15:0] v);
      if (v == 16'd0)         return 16'd0;
      else if (v < PW_MIN_W)  return PW_MIN_W;
      else if (v > PW_MAX_W)  return PW_MAX_W;
      else                    return v;
   endfunction

   always_comb begin
      tick_d      = tick_q;
      us_d        = us_q;
      en_d        = en_q;
      fcnt_d      = fcnt_q;
      pw_d        = pw_q;
      shadow_en_d = shadow_en_q;
      shadow_pw_d = shadow_pw_q;
      rdata       = 16'd0;

      frame_start = (tick_q == '0) && (us_q == '0);

      if (tick_q == TICK_LAST) begin
         tick_d = '0;
         us_d   = (us_q == US_LAST) ? '0 : us_q + 1'b1;
      end else begin
         tick_d = tick_q + 1'b1;
      end

      // Strobe capture: write wins over a simultaneous read.
      req_d      = (bus_read_in || bus_write_in) && (bus_addr_in[15:5] == BASE_ADDR[15:5]);
      req_wr_d   = bus_write_in;
      req_off_d  = bus_addr_in[4:0];
      req_data_d = bus_data_in;

      // Shadows take the registers as they stand this cycle, so a write that
      // lands on the frame-start edge waits for the next frame.
      if (frame_start) begin
         shadow_en_d = en_q;
         shadow_pw_d = pw_q;
         fcnt_d      = fcnt_q + 16'd1;
      end

      if (req_q && req_wr_q) begin
         if (req_off_q == 5'd0) en_d = req_data_q[0];
         for (int i = 0; i < N_CH; i++) begin
            if (req_off_q == 5'(i + 2)) pw_d[i] = clamp_pw(req_data_q);
         end
      end

      if (req_q && !req_wr_q) begin
         if (req_off_q == 5'd0)      rdata = {15'd0, en_q};
         else if (req_off_q == 5'd1) rdata = fcnt_q;
         for (int i = 0; i < N_CH; i++) begin
            if (req_off_q == 5'(i + 2)) rdata = pw_q[i];
         end
      end

      // Use the shadow values that apply to the current counter state, so the
      // first microsecond of a frame already sees the freshly loaded width.
      for (int i = 0; i < N_CH; i++) begin
         pwm_d[i] = shadow_en_d && (shadow_pw_d[i] != 16'd0) &&
                    (32'(us_q) < 32'(shadow_pw_d[i]));
      end
      frame_d = frame_start;
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         req_q       <= 1'b0;
         req_wr_q    <= 1'b0;
         req_off_q   <= 5'd0;
         req_data_q  <= 16'd0;
         en_q        <= 1'b0;
         fcnt_q      <= 16'd0;
         shadow_en_q <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            pw_q[i]        <= 16'd0;
            shadow_pw_q[i] <= 16'd0;
         end
         tick_q  <= '0;
         us_q    <= '0;
         pwm_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         req_q       <= req_d;
         req_wr_q    <= req_wr_d;
         req_off_q   <= req_off_d;
         req_data_q  <= req_data_d;
         en_q        <= en_d;
         fcnt_q      <= fcnt_d;
         shadow_en_q <= shadow_en_d;
         pw_q        <= pw_d;
         shadow_pw_q <= shadow_pw_d;
         tick_q      <= tick_d;
         us_q        <= us_d;
         pwm_q       <= pwm_d;
         frame_q     <= frame_d;
      end
   end

   assign bus_ack_out   = req_q;
   assign bus_data_out  = rdata;
   assign servo_pwm_out = pwm_q;
   assign frame_out     = frame_q;

endmodule

// File: tb/tb_fcl_bus_servo_pwm.sv
// Testbench for fcl_bus_servo_pwm. Uses a short frame (CLK_DIV=2,
// FRAME_US=2600) so several frames fit in a short run; clamp limits keep
// their default values. The reference model tracks cycles since reset and
// derives every output from the register rules with plain arithmetic.
module tb_fcl_bus_servo_pwm;

   localparam logic [15:0] BASE     = 16'h0100;
   localparam int          N_CH     = 18;
   localparam int          CLK_DIV  = 2;
   localparam int          FRAME_US = 2600;
   localparam int          PW_MIN   = 500;
   localparam int          PW_MAX   = 2500;
   localparam int          L        = CLK_DIV * FRAME_US;  // clocks per frame

   logic            clk_in;
   logic            reset_in;
   logic [15:0]     bus_addr_in;
   logic [15:0]     bus_data_in;
   logic [15:0]     bus_data_out;
   logic            bus_read_in;
   logic            bus_write_in;
   logic            bus_ack_out;
   logic [N_CH-1:0] servo_pwm_out;
   logic            frame_out;

   int checks;
   int passes;

   fcl_bus_servo_pwm #(
      .BASE_ADDR(BASE), .N_CH(N_CH), .CLK_DIV(CLK_DIV),
      .FRAME_US(FRAME_US), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX)
   ) dut (
      .clk_in(clk_in), .reset_in(reset_in),
      .bus_addr_in(bus_addr_in), .bus_data_in(bus_data_in),
      .bus_data_out(bus_data_out), .bus_read_in(bus_read_in),
      .bus_write_in(bus_write_in), .bus_ack_out(bus_ack_out),
      .servo_pwm_out(servo_pwm_out), .frame_out(frame_out)
   );

   // ---------------- clock ----------------
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   // k counts clock cycles since reset went low; cycle k is a frame start when
   // k is a multiple of L. exp_* describe the DUT outputs in the cycle after
   // the edge at which they are computed.
   int              k;
   int              m_pos;
   logic            m_en;
   logic [15:0]     m_fc;
   int              m_pw [N_CH];
   logic            sh_en;
   int              sh_pw [N_CH];
   logic            p_valid;
   logic            p_wr;
   int              p_off;
   logic [15:0]     p_data;
   logic            exp_ack;
   logic [15:0]     exp_rdata;
   logic [N_CH-1:0] exp_pwm;
   logic            exp_frame;

   function automatic bit in_window(input logic [15:0] a);
      return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + 32);
   endfunction

   function automatic int clamp_model(input int v);
      if (v == 0)      return 0;
      if (v < PW_MIN)  return PW_MIN;
      if (v > PW_MAX)  return PW_MAX;
      return v;
   endfunction

   function automatic logic [15:0] model_read(input int off);
      if (off == 0) return {15'd0, m_en};
      if (off == 1) return m_fc;
      if (off >= 2 && off < 2 + N_CH) return 16'(m_pw[off-2]);
      return 16'd0;
   endfunction

   initial begin
      forever begin
         @(posedge clk_in);
         if (reset_in) begin
            k = 0; m_en = 1'b0; m_fc = 16'd0; sh_en = 1'b0;
            for (int i = 0; i < N_CH; i++) begin
               m_pw[i] = 0; sh_pw[i] = 0;
            end
            p_valid = 1'b0; p_wr = 1'b0; p_off = 0; p_data = 16'd0;
            exp_ack = 1'b0; exp_rdata = 16'd0; exp_pwm = '0; exp_frame = 1'b0;
         end else begin
            m_pos = k % L;
            exp_frame = (m_pos == 0);
            if (m_pos == 0) begin
               sh_en = m_en;
               for (int i = 0; i < N_CH; i++) sh_pw[i] = m_pw[i];
               m_fc = m_fc + 16'd1;
            end
            for (int i = 0; i < N_CH; i++)
               exp_pwm[i] = sh_en && (sh_pw[i] != 0) && ((m_pos / CLK_DIV) < sh_pw[i]);
            // write acked this cycle lands now, after the frame capture
            if (p_valid && p_wr) begin
               if (p_off == 0) m_en = p_data[0];
               else if (p_off >= 2 && p_off < 2 + N_CH) m_pw[p_off-2] = clamp_model(int'(p_data));
            end
            p_valid   = (bus_read_in || bus_write_in) && in_window(bus_addr_in);
            p_wr      = bus_write_in;
            p_off     = int'(bus_addr_in) - int'(BASE);
            p_data    = bus_data_in;
            exp_ack   = p_valid;
            exp_rdata = (p_valid && !p_wr) ? model_read(p_off) : 16'd0;
            k++;
         end
      end
   end

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] data);
      bus_read_in = rd; bus_write_in = wr; bus_addr_in = addr; bus_data_in = data;
      @(negedge clk_in);
      bus_read_in = 1'b0; bus_write_in = 1'b0;
   endtask

   task automatic wait_frame(output bit seen);
      int n;
      n = 0;
      while (frame_out !== 1'b1 && n < L + 20) begin
         @(negedge clk_in); n++;
      end
      seen = (frame_out === 1'b1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [15:0] zero_exp [3];
      zero_exp = '{16'd0, 16'd0, 16'd0};
      @(negedge clk_in); reset_in = 1'b1;
      repeat (3) @(negedge clk_in);
      checks++;
      if ({bus_ack_out, bus_data_out, servo_pwm_out, frame_out} !== '0)
         $display("FAIL reset_outputs: got ack=%b data=%h pwm=%h frame=%b required all 0",
                  bus_ack_out, bus_data_out, servo_pwm_out, frame_out);
      else passes++;
      reset_in = 1'b0;
      @(negedge clk_in);
      checks++;
      if (frame_out !== 1'b1) $display("FAIL first_frame: got %b required 1", frame_out);
      else passes++;
      @(negedge clk_in);
      checks++;
      if (frame_out !== 1'b0) $display("FAIL first_frame_width: got %b required 0", frame_out);
      else passes++;
      for (int off = 0; off < 3; off++) begin
         drive(1'b1, 1'b0, BASE + 16'(off), 16'd0);
         checks++;
         if (bus_ack_out !== 1'b1) $display("FAIL reset_read_ack[%0d]: got %b required 1", off, bus_ack_out);
         else passes++;
         // FRAME_CNT already counted the frame start on the reset-release cycle.
         checks++;
         if (bus_data_out !== ((off == 1) ? exp_rdata : zero_exp[off]) || (off == 1 && exp_rdata !== 16'd1))
            $display("FAIL reset_read_data[%0d]: got %h required %h", off, bus_data_out,
                     (off == 1) ? 16'd1 : 16'd0);
         else passes++;
         @(negedge clk_in);
         checks++;
         if (bus_ack_out !== 1'b0) $display("FAIL reset_ack_one_cycle[%0d]: got %b required 0", off, bus_ack_out);
         else passes++;
      end
   endtask

   task automatic test_clamp();
      logic [15:0] wv [9];
      logic [15:0] ev [9];
      wv = '{16'd1500, 16'd100, 16'd3000, 16'd0, 16'd1, 16'd499, 16'd2500, 16'd2501, 16'hFFFF};
      ev = '{16'd1500, 16'd500, 16'd2500, 16'd0, 16'd500, 16'd500, 16'd2500, 16'd2500, 16'd2500};
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 1'b1, BASE + 16'd2, wv[i]);
         checks++;
         if (bus_ack_out !== 1'b1 || bus_data_out !== 16'd0)
            $display("FAIL clamp_write_ack[%0d]: got ack=%b data=%h required ack=1 data=0000", i, bus_ack_out, bus_data_out);
         else passes++;
         drive(1'b1, 1'b0, BASE + 16'd2, 16'd0);
         checks++;
         if (bus_ack_out !== 1'b1 || bus_data_out !== ev[i])
            $display("FAIL clamp_readback[%0d]: got ack=%b data=%0d required ack=1 data=%0d", i, bus_ack_out, bus_data_out, ev[i]);
         else passes++;
      end
   endtask

   task automatic test_window();
      logic [15:0] addrs [3];
      logic        acks [3];
      addrs = '{BASE + 16'd32, BASE - 16'd1, BASE + 16'd31};
      acks  = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, addrs[i], 16'd0);
         checks++;
         if (bus_ack_out !== acks[i] || bus_data_out !== 16'd0)
            $display("FAIL window[%h]: got ack=%b data=%h required ack=%b data=0000",
                     addrs[i], bus_ack_out, bus_data_out, acks[i]);
         else passes++;
         @(negedge clk_in);
      end
      // FRAME_CNT is read-only: write is acked, value unchanged
      drive(1'b0, 1'b1, BASE + 16'd1, 16'hFFFF);
      checks++;
      if (bus_ack_out !== 1'b1) $display("FAIL fcnt_write_ack: got %b required 1", bus_ack_out);
      else passes++;
      drive(1'b1, 1'b0, BASE + 16'd1, 16'd0);
      checks++;
      if (bus_data_out !== exp_rdata || bus_data_out === 16'hFFFF)
         $display("FAIL fcnt_readonly: got %h required %h", bus_data_out, exp_rdata);
      else passes++;
   endtask

   task automatic test_rw_collide();
      drive(1'b1, 1'b1, BASE + 16'd2, 16'd2000);
      checks++;
      if (bus_ack_out !== 1'b1 || bus_data_out !== 16'd0)
         $display("FAIL collide_ack: got ack=%b data=%h required ack=1 data=0000", bus_ack_out, bus_data_out);
      else passes++;
      @(negedge clk_in);
      checks++;
      if (bus_ack_out !== 1'b0) $display("FAIL collide_single_ack: got %b required 0", bus_ack_out);
      else passes++;
      drive(1'b1, 1'b0, BASE + 16'd2, 16'd0);
      checks++;
      if (bus_data_out !== 16'd2000) $display("FAIL collide_write_wins: got %0d required 2000", bus_data_out);
      else passes++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] v;
      v = 16'($urandom_range(PW_MIN, PW_MAX));
      bus_write_in = 1'b1; bus_addr_in = BASE + 16'd3; bus_data_in = v;
      @(negedge clk_in);
      checks++;
      if (bus_ack_out !== 1'b1 || bus_data_out !== 16'd0)
         $display("FAIL b2b_first_ack: got ack=%b data=%h required ack=1 data=0000", bus_ack_out, bus_data_out);
      else passes++;
      bus_write_in = 1'b0; bus_read_in = 1'b1;
      @(negedge clk_in);
      bus_read_in = 1'b0;
      checks++;
      if (bus_ack_out !== 1'b1 || bus_data_out !== v)
         $display("FAIL b2b_second_ack: got ack=%b data=%0d required ack=1 data=%0d", bus_ack_out, bus_data_out, v);
      else passes++;
      @(negedge clk_in);
      checks++;
      if (bus_ack_out !== 1'b0) $display("FAIL b2b_ack_drop: got %b required 0", bus_ack_out);
      else passes++;
   endtask

   task automatic test_pwm();
      bit seen;
      int hi, other, tbad;
      for (int i = 0; i < N_CH; i++)
         drive(1'b0, 1'b1, BASE + 16'(i + 2), (i == 3) ? 16'd1000 : 16'd0);
      drive(1'b0, 1'b1, BASE, 16'd1);
      wait_frame(seen);
      checks++;
      if (!seen) $display("FAIL pwm_frame_wait: got no frame_out required frame_out within %0d cycles", L + 20);
      else passes++;
      hi = 0; other = 0; tbad = 0;
      for (int c = 0; c < L; c++) begin
         if (servo_pwm_out[3] === 1'b1) hi++;
         if ((servo_pwm_out & ~(N_CH'(8))) !== '0) other++;
         if (servo_pwm_out !== exp_pwm || frame_out !== exp_frame) tbad++;
         @(negedge clk_in);
      end
      checks++;
      if (hi != 1000 * CLK_DIV) $display("FAIL pwm_width: got %0d clocks required %0d", hi, 1000 * CLK_DIV);
      else passes++;
      checks++;
      if (other != 0) $display("FAIL pwm_other_low: got %0d active cycles required 0", other);
      else passes++;
      checks++;
      if (tbad != 0) $display("FAIL pwm_trace: got %0d differing cycles required 0", tbad);
      else passes++;
      checks++;
      if (frame_out !== 1'b1 || servo_pwm_out[3] !== 1'b1)
         $display("FAIL pwm_period: got frame=%b pwm3=%b required 1 1 after %0d clocks", frame_out, servo_pwm_out[3], L);
      else passes++;
   endtask

   // Entered on a frame-start cycle with channel 3 pulsing.
   task automatic test_clear_mid();
      int hi, hi2, tbad;
      hi = 0; hi2 = 0; tbad = 0;
      for (int c = 0; c < L; c++) begin
         if (servo_pwm_out[3] === 1'b1) hi++;
         if (servo_pwm_out !== exp_pwm) tbad++;
         if (c == 500) begin
            bus_write_in = 1'b1; bus_addr_in = BASE; bus_data_in = 16'd0;
         end else begin
            bus_write_in = 1'b0;
         end
         @(negedge clk_in);
      end
      checks++;
      if (hi != 1000 * CLK_DIV) $display("FAIL clear_full_width: got %0d clocks required %0d", hi, 1000 * CLK_DIV);
      else passes++;
      for (int c = 0; c < L; c++) begin
         if (servo_pwm_out !== '0) hi2++;
         if (servo_pwm_out !== exp_pwm) tbad++;
         @(negedge clk_in);
      end
      checks++;
      if (hi2 != 0) $display("FAIL clear_next_frame: got %0d active cycles required 0", hi2);
      else passes++;
      checks++;
      if (tbad != 0) $display("FAIL clear_trace: got %0d differing cycles required 0", tbad);
      else passes++;
   endtask

   task automatic test_random();
      int bad, tbad, act;
      logic rd, wr;
      bit seen;
      bad = 0; tbad = 0; act = 0;
      for (int j = 0; j < 150; j++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         bus_read_in = rd; bus_write_in = wr;
         bus_addr_in = BASE - 16'd4 + 16'($urandom_range(0, 39));
         bus_data_in = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 4000));
         @(negedge clk_in);
         bus_read_in = 1'b0; bus_write_in = 1'b0;
         for (int g = 0; g <= int'($urandom_range(0, 2)); g++) begin
            if (bus_ack_out !== exp_ack || bus_data_out !== exp_rdata ||
                servo_pwm_out !== exp_pwm || frame_out !== exp_frame) begin
               if (bad == 0)
                  $display("FAIL random_bus first diff: got ack=%b data=%h required ack=%b data=%h",
                           bus_ack_out, bus_data_out, exp_ack, exp_rdata);
               bad++;
            end
            @(negedge clk_in);
         end
      end
      checks++;
      if (bad != 0) $display("FAIL random_bus: got %0d differing cycles required 0", bad);
      else passes++;
      for (int i = 0; i < N_CH; i++)
         drive(1'b0, 1'b1, BASE + 16'(i + 2),
               (i == 0) ? 16'd1500 : 16'($urandom_range(0, 3000)));
      drive(1'b0, 1'b1, BASE, 16'hFFFF);
      wait_frame(seen);
      checks++;
      if (!seen) $display("FAIL random_frame_wait: got no frame_out required frame_out within %0d cycles", L + 20);
      else passes++;
      for (int c = 0; c < 2 * L; c++) begin
         if (servo_pwm_out !== exp_pwm || frame_out !== exp_frame) tbad++;
         if (servo_pwm_out !== '0) act++;
         @(negedge clk_in);
      end
      checks++;
      if (tbad != 0 || act == 0) $display("FAIL random_pwm_trace: got %0d differing cycles, %0d active required 0 and >0", tbad, act);
      else passes++;
   endtask

   // Entered on a frame-start cycle with channel 0 programmed to 1500 us.
   task automatic test_reset_mid();
      repeat (100) @(negedge clk_in);
      checks++;
      if (servo_pwm_out[0] !== 1'b1) $display("FAIL reset_mid_pre: got pwm0=%b required 1", servo_pwm_out[0]);
      else passes++;
      reset_in = 1'b1; bus_read_in = 1'b1; bus_addr_in = BASE + 16'd2;
      @(negedge clk_in);
      bus_read_in = 1'b0;
      checks++;
      if (bus_ack_out !== 1'b0 || bus_data_out !== 16'd0 || servo_pwm_out !== '0 || frame_out !== 1'b0)
         $display("FAIL reset_mid_outputs: got ack=%b data=%h pwm=%h frame=%b required all 0",
                  bus_ack_out, bus_data_out, servo_pwm_out, frame_out);
      else passes++;
      reset_in = 1'b0;
      @(negedge clk_in);
      checks++;
      if (frame_out !== 1'b1 || servo_pwm_out !== '0)
         $display("FAIL reset_mid_restart: got frame=%b pwm=%h required frame=1 pwm=0", frame_out, servo_pwm_out);
      else passes++;
      drive(1'b1, 1'b0, BASE + 16'd2, 16'd0);
      checks++;
      if (bus_ack_out !== 1'b1 || bus_data_out !== 16'd0)
         $display("FAIL reset_mid_pw_cleared: got ack=%b data=%h required ack=1 data=0000", bus_ack_out, bus_data_out);
      else passes++;
   endtask

   initial begin
      checks = 0; passes = 0;
      reset_in = 1'b1;
      bus_addr_in = 16'd0; bus_data_in = 16'd0;
      bus_read_in = 1'b0; bus_write_in = 1'b0;
      test_reset();
      test_clamp();
      test_window();
      test_rw_collide();
      test_back_to_back();
      test_pwm();
      test_clear_mid();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
